rom_row_scanner: RTL

- Sequences the triangle waveform ROM (8-bit address, 208-bit combinational row word) for the display path.
- On a start pulse, walks a programmed address range one row at a time and latches each row.
- Serializes each row MSB-first to a downstream pixel consumer using a valid/ready handshake.
- Reports row/column position, busy status and a frame-done pulse.

---
 rtl/rom_row_scanner.sv | 106 ++++++++++
 1 files changed

// File: rtl/rom_row_scanner.sv
// ==== rom_row_scanner : walks a ROM address range and serializes each row MSB-first ==== rev 1.0
`default_nettype none

module rom_row_scanner #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 208,
  parameter int COL_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              pix_out,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] row_idx,
  output logic [COL_W-1:0]  col_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_last;
  logic [DATA_W-1:0] r_shift;
  logic [COL_W-1:0]  r_col;
  logic              w_xfer;
  logic              w_row_end;
  logic              w_last_row;

  assign w_xfer     = (r_state == S_SHIFT) && pix_ready;
  assign w_row_end  = (r_col == COL_W'(DATA_W - 1));
  assign w_last_row = (r_row == r_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: w_next = S_SHIFT;
      S_SHIFT: if (w_xfer && w_row_end) w_next = w_last_row ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Row address doubles as the ROM address; it only advances when another row follows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row   <= '0;
      r_last  <= '0;
      r_shift <= '0;
      r_col   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row  <= first_addr;
            r_last <= last_addr;
          end
        end
        S_FETCH: begin
          r_shift <= rom_data;
          r_col   <= '0;
        end
        S_SHIFT: begin
          if (w_xfer) begin
            if (!w_row_end) begin
              r_shift <= {r_shift[DATA_W-2:0], 1'b0};
              r_col   <= r_col + COL_W'(1);
            end else if (!w_last_row) begin
              r_row <= r_row + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pix_valid = (r_state == S_SHIFT);
  assign pix_out   = pix_valid & r_shift[DATA_W-1];
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign rom_addr  = r_row;
  assign row_idx   = r_row;
  assign col_idx   = r_col;

endmodule

`default_nettype wire
